// File: rtl/sram_init_seq.sv
// -----------------------------------------------------------------------------
// sram_init_seq
// Walks every active pixel of a WIDTH x HEIGHT frame in raster order. For each
// pixel it looks up an init word from an external combinational table and then
// issues one SRAM write, holding the request until the controller acks it.
//
// Ports
//   i_Clk        sole clock, rising edge
//   i_Reset      synchronous active-high reset
//   i_Start      start a frame (honoured only in IDLE or DONE)
//   o_Busy       high while a frame is in progress (LOOKUP/WRITE)
//   o_Done       high once the whole frame has been written
//   o_InitAddr   {y, x} pixel address presented to the init-value table
//   i_InitData   init word returned by the table for o_InitAddr
//   o_WrReq      SRAM write request
//   o_WrAddr     SRAM write address {y, x}
//   o_WrData     SRAM write data
//   i_WrAck      write accepted on a cycle with o_WrReq and i_WrAck both high
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for i_Start
// LOOKUP | table output valid for {y, x}; capture it into the write regs
// WRITE  | o_WrReq held until i_WrAck, then advance or finish
// DONE   | frame complete; x/y hold the last pixel; i_Start restarts
// -----------------------------------------------------------------------------
module sram_init_seq #(
  parameter int WIDTH  = 800,
  parameter int HEIGHT = 480
) (
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic        i_Start,
  output logic        o_Busy,
  output logic        o_Done,
  output logic [18:0] o_InitAddr,
  input  logic [15:0] i_InitData,
  output logic        o_WrReq,
  output logic [18:0] o_WrAddr,
  output logic [15:0] o_WrData,
  input  logic        i_WrAck
);

  localparam logic [9:0] X_LAST = 10'(WIDTH - 1);
  localparam logic [8:0] Y_LAST = 9'(HEIGHT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    WRITE  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t     state;
  logic [9:0] x;
  logic [8:0] y;
  logic       x_last;
  logic       y_last;

  assign x_last     = (x == X_LAST);
  assign y_last     = (y == Y_LAST);
  assign o_InitAddr = {y, x};

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state    <= IDLE;
      x        <= '0;
      y        <= '0;
      o_WrReq  <= 1'b0;
      o_WrAddr <= '0;
      o_WrData <= '0;
      o_Busy   <= 1'b0;
      o_Done   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (i_Start) begin
            x      <= '0;
            y      <= '0;
            o_Busy <= 1'b1;
            o_Done <= 1'b0;
            state  <= LOOKUP;
          end
        end

        LOOKUP: begin
          o_WrAddr <= {y, x};
          o_WrData <= i_InitData;
          o_WrReq  <= 1'b1;
          state    <= WRITE;
        end

        WRITE: begin
          // Only reachable with o_WrReq high, so an ack here is always real.
          if (i_WrAck) begin
            o_WrReq <= 1'b0;
            if (x_last && y_last) begin
              o_Busy <= 1'b0;
              o_Done <= 1'b1;
              state  <= DONE;
            end else begin
              if (x_last) begin
                x <= '0;
                y <= y + 9'd1;
              end else begin
                x <= x + 10'd1;
              end
              state <= LOOKUP;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
